// File: rtl/seg7_scan_if.sv
// Bundles the scan controller's control inputs and display outputs.
// The master side drives the value and strobes; the slave side is the scan controller.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int CODE_W     = 4
);
  logic                         en;
  logic                         load;
  logic [NUM_DIGITS*CODE_W-1:0] value;
  logic                         lz_blank;
  logic [CODE_W-1:0]            digit_code;
  logic [NUM_DIGITS-1:0]        anode;
  logic                         pending;
  logic                         frame_done;

  modport master (
    output en, load, value, lz_blank,
    input  digit_code, anode, pending, frame_done
  );

  modport slave (
    input  en, load, value, lz_blank,
    output digit_code, anode, pending, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed digit scanner feeding one shared segment decoder.
// New values wait in a shadow register and are committed only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CODE_W     = 4,
  parameter int DWELL      = 4,
  parameter int GAP_CYC    = 1
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);
  localparam int VAL_W   = NUM_DIGITS * CODE_W;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (DWELL > GAP_CYC) ? DWELL : GAP_CYC;
  localparam int PW      = $clog2(CNT_MAX + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] DWELL_END = PW'(DWELL - 1);
  localparam logic [PW-1:0] GAP_END   = PW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic                  fdone_q, fdone_d;
  logic                  commit;
  logic [NUM_DIGITS-1:0] blank;

  // Digit i>0 is dark when it and every more-significant digit are zero.
  function automatic logic [NUM_DIGITS-1:0] blank_mask(input logic [VAL_W-1:0] v,
                                                       input logic             lz);
    logic [NUM_DIGITS-1:0] m;
    logic                  zeros_above;
    m           = '0;
    zeros_above = lz;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zeros_above = zeros_above && (v[i*CODE_W +: CODE_W] == '0);
      m[i]        = zeros_above;
    end
    return m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = SHOW;
          idx_d   = '0;
          pre_d   = '0;
          commit  = 1'b1;
        end
      end
      SHOW: begin
        if (!bus.en) begin
          state_d = IDLE;
          idx_d   = '0;
          pre_d   = '0;
        end else if (pre_q == DWELL_END) begin
          pre_d = '0;
          if (GAP_CYC > 0) begin
            state_d = GAP;
          end else if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            commit = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      GAP: begin
        if (!bus.en) begin
          state_d = IDLE;
          idx_d   = '0;
          pre_d   = '0;
        end else if (pre_q == GAP_END) begin
          state_d = SHOW;
          pre_d   = '0;
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            commit = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A load coinciding with a commit lands in the shadow and stays pending.
    disp_d    = (commit && pending_q) ? shadow_q : disp_q;
    shadow_d  = bus.load ? bus.value : shadow_q;
    pending_d = bus.load | (pending_q & ~commit);

    // Outputs are registered, so they are computed from the upcoming state.
    blank   = blank_mask(disp_d, bus.lz_blank);
    anode_d = '0;
    code_d  = code_q;
    if (state_d == SHOW) begin
      anode_d[idx_d] = ~blank[idx_d];
      code_d         = disp_d[idx_d*CODE_W +: CODE_W];
    end

    // frame_done marks the final cycle of a frame, i.e. the cycle ending in the wrap.
    if (GAP_CYC > 0) begin
      fdone_d = (state_d == GAP) && (idx_d == LAST_IDX) && (pre_d == GAP_END);
    end else begin
      fdone_d = (state_d == SHOW) && (idx_d == LAST_IDX) && (pre_d == DWELL_END);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      anode_q   <= '0;
      code_q    <= '0;
      fdone_q   <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      anode_q   <= anode_d;
      code_q    <= code_d;
      fdone_q   <= fdone_d;
    end
  end

  assign bus.anode      = anode_q;
  assign bus.digit_code = code_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = fdone_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: frame-position reference model,
// table-driven frame checks, directed corner sequences and random traffic.
module tb_seg7_scan_ctrl;
  localparam int ND    = 4;
  localparam int CW    = 4;
  localparam int DW    = 4;
  localparam int GC    = 1;
  localparam int P     = DW + GC;
  localparam int FRAME = ND * P;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(ND), .CODE_W(CW)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS(ND),
    .CODE_W    (CW),
    .DWELL     (DW),
    .GAP_CYC   (GC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within the frame plus shadow/display contents.
  logic        m_run;
  int          m_t;
  logic [15:0] m_shadow, m_disp;
  logic        m_pend;
  logic [3:0]  e_anode, e_code;
  logic        e_fd;

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [15:0] anodes;
    logic [15:0] codes;
  } vec_t;
  vec_t tbl [6];

  logic [15:0] rv, v, w, exp_v;
  int          slot, guard;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_t = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0;
    e_anode = '0; e_code = '0; e_fd = 1'b0;
  endtask

  task automatic model_step();
    logic commit;
    int   s, off;
    commit = bus.en && (!m_run || m_t == FRAME - 1);
    if (!bus.en) m_run = 1'b0;
    else if (!m_run) begin m_run = 1'b1; m_t = 0; end
    else m_t = (m_t + 1) % FRAME;
    if (commit && m_pend) m_disp = m_shadow;
    if (bus.load) begin m_pend = 1'b1; m_shadow = bus.value; end
    else if (commit) m_pend = 1'b0;
    e_anode = '0;
    e_fd    = 1'b0;
    if (m_run) begin
      s   = m_t / P;
      off = m_t % P;
      if (off < DW) begin
        e_code = 4'(m_disp >> (s * CW));
        if (!(bus.lz_blank && s > 0 && (m_disp >> (s * CW)) == 16'h0))
          e_anode = 4'(1 << s);
      end
      e_fd = (m_t == FRAME - 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("mdl_anode",   bus.anode,      e_anode);
    chk("mdl_code",    bus.digit_code, e_code);
    chk("mdl_pending", bus.pending,    m_pend);
    chk("mdl_fdone",   bus.frame_done, e_fd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.en = 1'b0; bus.load = 1'b0; bus.value = '0; bus.lz_blank = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_anode",   bus.anode,      0);
    chk("rst_code",    bus.digit_code, 0);
    chk("rst_pending", bus.pending,    0);
    chk("rst_fdone",   bus.frame_done, 0);
  endtask

  // Called at posedge+1; raises rst mid-cycle and checks the outputs clear before the next edge.
  task automatic async_rst_check(input string nm);
    chk({nm, "_pend_before"}, bus.pending, 1);
    #2 rst = 1'b1;
    #1;
    chk({nm, "_anode"}, bus.anode,      0);
    chk({nm, "_code"},  bus.digit_code, 0);
    chk({nm, "_pend"},  bus.pending,    0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.value = '0; bus.lz_blank = 1'b0;
    model_reset();

    tbl[0] = '{16'h1234, 1'b0, 16'h8421, 16'h1234};
    tbl[1] = '{16'h0070, 1'b1, 16'h0021, 16'h0070};
    tbl[2] = '{16'h0000, 1'b1, 16'h0001, 16'h0000};
    tbl[3] = '{16'h0000, 1'b0, 16'h8421, 16'h0000};
    tbl[4] = '{16'h0501, 1'b1, 16'h0421, 16'h0501};
    tbl[5] = '{16'hF00A, 1'b1, 16'h8421, 16'hF00A};

    // Table: one full frame per entry, starting from reset
    for (int k = 0; k < 6; k++) begin
      do_reset();
      bus.lz_blank = tbl[k].lz;
      bus.value    = tbl[k].value;
      bus.load     = 1'b1;
      tick();
      bus.load = 1'b0;
      chk("tbl_pend_loaded", bus.pending, 1);
      bus.en = 1'b1;
      for (int c = 0; c < FRAME; c++) begin
        tick();
        slot = c / P;
        if (c % P < DW) begin
          chk("tbl_anode", bus.anode,      tbl[k].anodes[slot*4 +: 4]);
          chk("tbl_code",  bus.digit_code, tbl[k].codes[slot*4 +: 4]);
        end else begin
          chk("tbl_gap_anode", bus.anode, 0);
        end
        chk("tbl_fdone", bus.frame_done, (c == FRAME - 1));
        chk("tbl_pend",  bus.pending,    0);
      end
      tick();
      chk("tbl_wrap_anode", bus.anode, tbl[k].anodes[3:0]);
      bus.en = 1'b0;
    end

    // Mid-frame load is held back until the wrap
    do_reset();
    v = 16'h1234; w = 16'hABCD;
    bus.value = v; bus.load = 1'b1; tick(); bus.load = 1'b0;
    bus.en = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    bus.load = 1'b1; bus.value = w;
    for (int t = 8; t < 40; t++) begin
      tick();
      bus.load = 1'b0;
      exp_v = (t < 20) ? v : w;
      chk("t3_pend", bus.pending, (t < 20));
      if (t % P < DW) chk("t3_code", bus.digit_code, (exp_v >> (((t % FRAME) / P) * 4)) & 16'hF);
    end

    // Load on the frame_done cycle with a value already pending
    do_reset();
    bus.value = 16'h1111; bus.load = 1'b1; tick(); bus.load = 1'b0;
    bus.en = 1'b1; tick(); tick();
    bus.value = 16'h2222; bus.load = 1'b1; tick(); bus.load = 1'b0;
    tick();
    bus.value = 16'h3333; bus.load = 1'b1; tick(); bus.load = 1'b0;
    guard = 0;
    while (bus.frame_done !== 1'b1 && guard < 50) begin tick(); guard++; end
    chk("t4_fd_seen", bus.frame_done, 1);
    bus.value = 16'h4444; bus.load = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      bus.load = 1'b0;
      chk("t4_pend", bus.pending, 1);
      if (c % P < DW) chk("t4_code", bus.digit_code, 3);
    end
    tick();
    chk("t4_next_code", bus.digit_code, 4);
    chk("t4_next_pend", bus.pending,    0);

    // en dropped during digit 2, then re-enabled
    do_reset();
    bus.value = 16'h1234; bus.load = 1'b1; tick(); bus.load = 1'b0;
    bus.en = 1'b1;
    for (int t = 0; t < 11; t++) tick();
    chk("t5_digit2", bus.anode, 4'b0100);
    bus.en = 1'b0;
    tick();
    chk("t5_off_anode", bus.anode,      0);
    chk("t5_off_fd",    bus.frame_done, 0);
    for (int t = 0; t < 25; t++) begin
      tick();
      chk("t5_idle_fd", bus.frame_done, 0);
    end
    bus.en = 1'b1;
    tick();
    chk("t5_restart_anode", bus.anode,      4'b0001);
    chk("t5_restart_code",  bus.digit_code, 4);

    // Asynchronous reset mid-GAP and mid-SHOW with a value pending
    for (int r = 0; r < 2; r++) begin
      do_reset();
      bus.value = 16'h5678; bus.load = 1'b1; tick(); bus.load = 1'b0;
      bus.en = 1'b1; tick(); tick();
      bus.value = 16'h9ABC; bus.load = 1'b1; tick(); bus.load = 1'b0;
      tick(); tick();
      if (r == 1) begin tick(); tick(); end
      async_rst_check((r == 0) ? "t6_gap" : "t6_show");
      bus.en = 1'b1;
      tick();
      chk("t6_restart_anode", bus.anode, 4'b0001);
      bus.en = 1'b0;
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.en   = ($urandom_range(0, 59) != 0);
      bus.load = ($urandom_range(0, 9) == 0);
      if (bus.load) begin
        rv = 16'($urandom);
        for (int j = 0; j < 4; j++)
          if ($urandom_range(0, 2) == 0) rv[j*4 +: 4] = 4'h0;
        bus.value = rv;
      end
      if ($urandom_range(0, 49) == 0) bus.lz_blank = ~bus.lz_blank;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
